// File: rtl/lsu_byte_seq.sv
// ---------------------------------------------------------------------------
// lsu_byte_seq
//
// Load/store initiator for a byte-wide data memory. Takes one byte, halfword
// or word access from the execute stage over a valid/ready handshake, breaks
// it into single-byte memory cycles (little-endian, lowest address first) and
// returns one response. Loads are sign- or zero-extended to XLEN.
//
// Parameters
//   AWIDTH : memory byte-address width (must match the memory instance)
//   XLEN   : request address/data width (32 or wider)
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : request handshake
//   req_we              : 1 = store, 0 = load
//   req_size            : 00 byte, 01 halfword, 10 word, 11 illegal
//   req_unsigned        : zero-extend loads when 1
//   req_addr            : byte address, only [AWIDTH-1:0] used
//   req_wdata           : right-aligned store data
//   rsp_valid           : one-cycle response pulse
//   rsp_rdata           : extended load data, 0 for stores and errors
//   rsp_err             : 1 = illegal size
//   mem_addr/mem_wdata/mem_wen : byte memory request
//   mem_rdata           : byte memory read data (combinational on mem_addr)
// ---------------------------------------------------------------------------
module lsu_byte_seq #(
   parameter int AWIDTH = 8,
   parameter int XLEN   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [XLEN-1:0]   req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              rsp_valid,
   output logic [XLEN-1:0]   rsp_rdata,
   output logic              rsp_err,
   output logic [AWIDTH-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              mem_wen,
   input  logic [7:0]        mem_rdata
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   state_t            r_state;
   logic              r_ready;
   logic              r_rsp_valid;
   logic              r_rsp_err;
   logic [XLEN-1:0]   r_rsp_rdata;

   // Fields latched at acceptance; request inputs are ignored after that.
   logic              r_we;
   logic [1:0]        r_size;
   logic              r_uns;
   logic [AWIDTH-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic [31:0]       r_buf;
   logic [1:0]        r_beat;

   logic              w_access;
   logic              w_last;
   logic [31:0]       w_buf_next;
   logic              w_unused;

   // Address bits above AWIDTH-1 are deliberately dropped.
   assign w_unused = ^req_addr;

   // Index of the final beat for the latched size (size 11 never reaches ACCESS).
   function automatic logic [1:0] f_last_beat(input logic [1:0] size);
      case (size)
         2'b00:   f_last_beat = 2'd0;
         2'b01:   f_last_beat = 2'd1;
         default: f_last_beat = 2'd3;
      endcase
   endfunction

   // Extend the assembled little-endian buffer to XLEN; the sign bit is the
   // top bit of the accessed width.
   function automatic logic [XLEN-1:0] f_extend(input logic [31:0] b,
                                                input logic [1:0]  size,
                                                input logic        uns);
      logic signed [7:0]  sb;
      logic signed [15:0] sh;
      logic signed [31:0] sw;
      sb = b[7:0];
      sh = b[15:0];
      sw = b;
      case (size)
         2'b00: begin
            if (uns) f_extend = XLEN'(b[7:0]);
            else     f_extend = XLEN'(sb);
         end
         2'b01: begin
            if (uns) f_extend = XLEN'(b[15:0]);
            else     f_extend = XLEN'(sh);
         end
         default: begin
            if (uns) f_extend = XLEN'(b);
            else     f_extend = XLEN'(sw);
         end
      endcase
   endfunction

   assign w_access = (r_state == S_ACCESS);
   assign w_last   = (r_beat == f_last_beat(r_size));

   // Buffer as it will look once the current beat's read byte is merged, so
   // the response can be formed on the same edge as the last capture.
   always_comb begin
      w_buf_next = r_buf;
      w_buf_next[{r_beat, 3'b000} +: 8] = mem_rdata;
   end

   // Memory side is decoded from registered state only; everything is forced
   // to zero during reset so no partial store beat can land.
   assign mem_addr  = (w_access && !rst) ? (r_addr + AWIDTH'(r_beat)) : '0;
   assign mem_wen   = w_access & r_we & ~rst;
   assign mem_wdata = (w_access && r_we && !rst) ? r_wdata[{r_beat, 3'b000} +: 8] : 8'h00;

   assign req_ready = r_ready & ~rst;
   assign rsp_valid = r_rsp_valid & ~rst;
   assign rsp_err   = r_rsp_err & ~rst;
   assign rsp_rdata = rst ? '0 : r_rsp_rdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_ready     <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;
         r_beat      <= 2'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_rsp_valid <= 1'b0;
               r_rsp_err   <= 1'b0;
               r_rsp_rdata <= '0;
               if (req_valid && r_ready) begin
                  r_we    <= req_we;
                  r_size  <= req_size;
                  r_uns   <= req_unsigned;
                  r_addr  <= req_addr[AWIDTH-1:0];
                  r_wdata <= req_wdata[31:0];
                  r_beat  <= 2'd0;
                  r_ready <= 1'b0;
                  if (req_size == 2'b11) begin
                     // Illegal size: respond immediately, touch no memory.
                     r_state     <= S_RESP;
                     r_rsp_valid <= 1'b1;
                     r_rsp_err   <= 1'b1;
                  end else begin
                     r_state <= S_ACCESS;
                  end
               end else begin
                  r_ready <= 1'b1;
               end
            end
            S_ACCESS: begin
               r_buf <= w_buf_next;
               if (w_last) begin
                  r_state     <= S_RESP;
                  r_rsp_valid <= 1'b1;
                  r_rsp_rdata <= r_we ? '0 : f_extend(w_buf_next, r_size, r_uns);
               end else begin
                  r_beat <= r_beat + 2'd1;
               end
            end
            S_RESP: begin
               r_state     <= S_IDLE;
               r_rsp_valid <= 1'b0;
               r_rsp_err   <= 1'b0;
               r_rsp_rdata <= '0;
               r_ready     <= 1'b1;
            end
            default: begin
               r_state <= S_IDLE;
               r_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_byte_seq.sv
// ---------------------------------------------------------------------------
// tb_lsu_byte_seq
//
// Bench for lsu_byte_seq with a 256-byte memory model attached. A table of
// directed requests with hand-computed results is applied in a loop, then
// back-to-back and reset-during-store sequences are run by hand.
// ---------------------------------------------------------------------------
module tb_lsu_byte_seq;

   localparam int AW = 8;
   localparam int XL = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [1:0]    req_size;
   logic          req_unsigned;
   logic [XL-1:0] req_addr;
   logic [XL-1:0] req_wdata;
   logic          rsp_valid;
   logic [XL-1:0] rsp_rdata;
   logic          rsp_err;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wdata;
   logic          mem_wen;
   logic [7:0]    mem_rdata;

   logic [7:0]    mem [0:255];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   lsu_byte_seq #(.AWIDTH(AW), .XLEN(XL)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_wen      (mem_wen),
      .mem_rdata    (mem_rdata)
   );

   assign mem_rdata = mem[mem_addr];

   always @(posedge clk) begin
      if (mem_wen) mem[mem_addr] <= mem_wdata;
   end

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs [13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic do_req(input vec_t v, input int idx);
      int n;
      int nb;
      logic [7:0]  eaddr;
      logic [31:0] eb;
      nb = (v.size == 2'b00) ? 1 : (v.size == 2'b01) ? 2 : (v.size == 2'b10) ? 4 : 0;
      @(negedge clk);
      req_valid    = 1'b1;
      req_we       = v.we;
      req_size     = v.size;
      req_unsigned = v.uns;
      req_addr     = v.addr;
      req_wdata    = v.wdata;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         chk($sformatf("v%0d accept_timeout", idx), 32'(req_ready), 32'd1);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      // Scramble request inputs while busy; they must not matter.
      req_valid    = 1'b0;
      req_we       = ~v.we;
      req_size     = 2'b11;
      req_unsigned = ~v.uns;
      req_addr     = 32'h0000_0055;
      req_wdata    = 32'h0;
      for (int k = 1; k <= nb + 2; k++) begin
         @(negedge clk);
         if (k <= nb) begin
            eaddr = v.addr[7:0] + 8'(k - 1);
            eb    = v.we ? ((v.wdata >> (8 * (k - 1))) & 32'hFF) : 32'h0;
            chk($sformatf("v%0d k%0d mem_addr", idx, k), 32'(mem_addr), 32'(eaddr));
            chk($sformatf("v%0d k%0d mem_wen", idx, k), 32'(mem_wen), 32'(v.we));
            chk($sformatf("v%0d k%0d mem_wdata", idx, k), 32'(mem_wdata), eb);
            chk($sformatf("v%0d k%0d rsp_valid", idx, k), 32'(rsp_valid), 32'd0);
            chk($sformatf("v%0d k%0d req_ready", idx, k), 32'(req_ready), 32'd0);
         end else if (k == nb + 1) begin
            chk($sformatf("v%0d rsp_valid", idx), 32'(rsp_valid), 32'd1);
            chk($sformatf("v%0d rsp_rdata", idx), rsp_rdata, v.exp_rdata);
            chk($sformatf("v%0d rsp_err", idx), 32'(rsp_err), 32'(v.exp_err));
            chk($sformatf("v%0d resp req_ready", idx), 32'(req_ready), 32'd0);
            chk($sformatf("v%0d resp mem_wen", idx), 32'(mem_wen), 32'd0);
         end else begin
            chk($sformatf("v%0d ready_after", idx), 32'(req_ready), 32'd1);
            chk($sformatf("v%0d rsp_valid_after", idx), 32'(rsp_valid), 32'd0);
         end
      end
   endtask

   initial begin
      int   pulses;
      vec_t v;

      for (int i = 0; i < 256; i++) mem[i] = 8'hA5;
      rst          = 1'b1;
      req_valid    = 1'b0;
      req_we       = 1'b0;
      req_size     = 2'b00;
      req_unsigned = 1'b0;
      req_addr     = '0;
      req_wdata    = '0;

      // Reset state.
      repeat (3) @(negedge clk);
      chk("rst req_ready", 32'(req_ready), 32'd0);
      chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst rsp_rdata", rsp_rdata, 32'd0);
      chk("rst rsp_err", 32'(rsp_err), 32'd0);
      chk("rst mem_wen", 32'(mem_wen), 32'd0);
      chk("rst mem_addr", 32'(mem_addr), 32'd0);
      chk("rst mem_wdata", 32'(mem_wdata), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst req_ready", 32'(req_ready), 32'd1);
      chk("post_rst rsp_valid", 32'(rsp_valid), 32'd0);
      chk("post_rst mem_wen", 32'(mem_wen), 32'd0);
      chk("post_rst mem_addr", 32'(mem_addr), 32'd0);

      //           we    size   uns   addr          wdata         exp_rdata     err
      vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
      vecs[1]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
      vecs[2]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0020, 32'h1234_5680, 32'h0000_0000, 1'b0};
      vecs[3]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0020, 32'h0,         32'hFFFF_FF80, 1'b0};
      vecs[4]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0020, 32'h0,         32'h0000_0080, 1'b0};
      vecs[5]  = '{1'b1, 2'b01, 1'b0, 32'h0000_00FF, 32'hFFFF_1234, 32'h0000_0000, 1'b0};
      vecs[6]  = '{1'b0, 2'b01, 1'b0, 32'h0000_00FF, 32'h0,         32'h0000_1234, 1'b0};
      vecs[7]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0000, 32'h0,         32'h0000_0012, 1'b0};
      vecs[8]  = '{1'b1, 2'b11, 1'b0, 32'h0000_0030, 32'h1122_3344, 32'h0000_0000, 1'b1};
      vecs[9]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0,         32'hFFFF_DEAD, 1'b0};
      vecs[10] = '{1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'h0,         32'h0000_DEAD, 1'b0};
      vecs[11] = '{1'b0, 2'b10, 1'b0, 32'hABCD_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
      vecs[12] = '{1'b0, 2'b11, 1'b1, 32'h0000_0010, 32'h0,         32'h0000_0000, 1'b1};

      for (int i = 0; i < 13; i++) do_req(vecs[i], i);

      chk("mem[10]", 32'(mem[8'h10]), 32'hEF);
      chk("mem[11]", 32'(mem[8'h11]), 32'hBE);
      chk("mem[12]", 32'(mem[8'h12]), 32'hAD);
      chk("mem[13]", 32'(mem[8'h13]), 32'hDE);
      chk("mem[20]", 32'(mem[8'h20]), 32'h80);
      chk("mem[21]", 32'(mem[8'h21]), 32'hA5);
      chk("mem[FF]", 32'(mem[8'hFF]), 32'h34);
      chk("mem[00]", 32'(mem[8'h00]), 32'h12);
      chk("mem[30] illegal", 32'(mem[8'h30]), 32'hA5);

      // Back-to-back word loads with req_valid held high.
      @(negedge clk);
      req_valid    = 1'b1;
      req_we       = 1'b0;
      req_size     = 2'b10;
      req_unsigned = 1'b0;
      req_addr     = 32'h10;
      req_wdata    = 32'h0;
      chk("b2b ready_pre", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      pulses = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         chk($sformatf("b2b k%0d req_ready", k), 32'(req_ready),
             (k == 6 || k == 12) ? 32'd1 : 32'd0);
         if (rsp_valid) pulses++;
         if (k == 5 || k == 11) begin
            chk($sformatf("b2b k%0d rsp_valid", k), 32'(rsp_valid), 32'd1);
            chk($sformatf("b2b k%0d rsp_rdata", k), rsp_rdata, 32'hDEAD_BEEF);
         end else begin
            chk($sformatf("b2b k%0d rsp_valid", k), 32'(rsp_valid), 32'd0);
         end
         if (k == 2) begin
            req_addr = 32'h77;
            req_we   = 1'b1;
         end
         if (k == 4) begin
            req_addr = 32'h10;
            req_we   = 1'b0;
         end
         if (k == 6) begin
            @(posedge clk);
            #1;
            req_valid = 1'b0;
         end
      end
      chk("b2b pulses", 32'(pulses), 32'd2);
      chk("b2b no_store", 32'(mem[8'h77]), 32'hA5);

      // Reset during the third beat of a word store.
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_size  = 2'b10;
      req_addr  = 32'h40;
      req_wdata = 32'hAABB_CCDD;
      chk("rmid ready_pre", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      chk("rmid b0 mem_wen", 32'(mem_wen), 32'd1);
      chk("rmid b0 mem_addr", 32'(mem_addr), 32'h40);
      @(negedge clk);
      chk("rmid b1 mem_addr", 32'(mem_addr), 32'h41);
      chk("rmid b1 mem_wdata", 32'(mem_wdata), 32'hCC);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk("rmid rst mem_wen", 32'(mem_wen), 32'd0);
      chk("rmid rst rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rmid rst req_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rmid fall rsp_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      chk("rmid ready_after", 32'(req_ready), 32'd1);
      pulses = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (rsp_valid || mem_wen) pulses++;
      end
      chk("rmid no_activity", 32'(pulses), 32'd0);
      chk("rmid mem[40]", 32'(mem[8'h40]), 32'hDD);
      chk("rmid mem[41]", 32'(mem[8'h41]), 32'hCC);
      chk("rmid mem[42]", 32'(mem[8'h42]), 32'hA5);
      chk("rmid mem[43]", 32'(mem[8'h43]), 32'hA5);

      // Normal operation resumes after the aborted store.
      v = '{1'b0, 2'b10, 1'b1, 32'h0000_0040, 32'h0, 32'hA5A5_CCDD, 1'b0};
      do_req(v, 99);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/lsu_byte_seq.md
Name: lsu_byte_seq

Overview:
- Load/store initiator for the processor's byte-wide data memory; the requesting end of the memory's address/wdata/wen/rdata interface.
- Accepts one byte, halfword or word load/store from the execute stage via a valid/ready handshake.
- Splits each access into sequential single-byte memory cycles in little-endian order and returns one response.
- Loads are sign- or zero-extended.

Parameters:
- AWIDTH, 8, data memory address width; must match the memory instance.
- XLEN, 32, width of request address and data words.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous reset, active-high
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request this cycle
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
- req_addr  input  XLEN  byte address; only bits [AWIDTH-1:0] are used
- req_wdata  input  XLEN  store data, right-aligned
- rsp_valid  output  1  one-cycle response pulse
- rsp_rdata  output  XLEN  extended load data; 0 for stores and errors
- rsp_err  output  1  qualifies rsp_valid; 1 = illegal size
- mem_addr  output  AWIDTH  memory byte address
- mem_wdata  output  8  memory write byte
- mem_wen  output  1  memory write enable
- mem_rdata  input  8  memory read byte; combinational read of mem_addr

Behaviour:
- Reset state: all outputs 0 while rst is high, including req_ready and mem_wen. One cycle after rst falls, req_ready = 1 and all other outputs remain 0.
- State machine: IDLE, ACCESS, RESP.
  - IDLE: req_ready = 1. mem_addr, mem_wdata and mem_wen are 0.
  - Handshake: a request is accepted on a rising edge where req_valid && req_ready. On acceptance, latch we, size, unsigned, addr[AWIDTH-1:0] and wdata.
  - Beat count N: 1, 2 or 4 for sizes 00, 01, 10.
- Legal accept: IDLE -> ACCESS with beat counter i = 0.
- Illegal size (11): IDLE -> RESP directly. No memory cycle is issued. rsp_err = 1.
- ACCESS, beat i:
  - req_ready = 0.
  - mem_addr = latched addr + i, modulo 2^AWIDTH; wraps from 2^AWIDTH-1 to 0.
  - Store beat: mem_wen = 1 and mem_wdata = wdata[8i+7:8i].
  - Load beat: mem_wen = 0 and mem_wdata = 0; mem_rdata is captured into buffer byte i at the end of the beat.
  - When i == N-1, go to RESP; otherwise increment i.
- RESP, held for exactly one cycle:
  - rsp_valid = 1 and req_ready = 0.
  - Load response: rsp_rdata = buffer[8N-1:0] extended to XLEN. Sign bit is buffer bit 8N-1 unless unsigned is set.
  - Store response: rsp_rdata = 0.
  - Next state is IDLE.
- Latency, with the accept edge at cycle T:
  - Beats occupy cycles T+1 .. T+N.
  - rsp_valid is high in cycle T+N+1.
  - req_ready is high again in cycle T+N+2.
  - Illegal requests: rsp_valid in T+1.
- Throughput: one request in flight; no pipelining. req_valid arriving while busy is held off by req_ready = 0.
- Alignment: no alignment requirement. Any address is legal, because memory is byte-addressed.
- Upper address bits: req_addr bits above AWIDTH-1 are ignored.
- Request signals during ACCESS/RESP: changes to req_* have no effect.
- Reset mid-operation:
  - rst high in any state forces IDLE on the next edge, discards the transaction and produces no response.
  - mem_wen is gated to 0 combinationally whenever rst is high, so no partial store beat is written in a reset cycle.
  - Store bytes already written before reset remain in memory.
- No combinational path from req_* to mem_* or rsp_*. All memory-side outputs are decoded from registered state and latched fields only.

Test Plan:
- Store word 0xDEADBEEF at addr 0x10, then load word from 0x10:
  - Store: mem writes 0xEF, 0xBE, 0xAD, 0xDE to addresses 0x10..0x13 on consecutive cycles; rsp_valid at T+5.
  - Load: rsp_rdata = 0xDEADBEEF, rsp_err = 0.
- Byte 0x80 at 0x20:
  - Signed byte load: rsp_rdata = 0xFFFFFF80.
  - Unsigned byte load: rsp_rdata = 0x00000080.
  - Each load has rsp_valid at T+2.
- Halfword wrap-around: store halfword 0x1234 at 0xFF (AWIDTH = 8) -> mem[0xFF] = 0x34, mem[0x00] = 0x12. Signed halfword load from 0xFF returns 0x00001234.
- Illegal size 11 with req_valid -> no mem_wen pulse; rsp_valid at T+1 with rsp_err = 1 and rsp_rdata = 0.
- Back-to-back: hold req_valid high across two word loads -> req_ready low T+1..T+5. Second accept occurs at the T+6 edge, and each request gets exactly one rsp_valid pulse.
- Reset mid-store:
  - Stimulus: assert rst during beat 2 of a word store of 0xAABBCCDD at 0x40.
  - Memory: 0x40 = 0xDD and 0x41 = 0xCC are written; 0x42 and 0x43 are unchanged; mem_wen = 0 during the reset cycle.
  - Response: no rsp_valid pulse; req_ready = 1 one cycle after rst falls.
